ahb_slave_sram: RTL and testbench
=================================

// Module: ahb_slave_sram
// PURPOSE
//  AHB slave with an internal word-addressed SRAM; the responder end of the
//  ahb_master bus. Decodes NONSEQ/SEQ transfers and inserts a fixed number of
//  wait states. Performs byte/halfword/word reads and writes. Returns a
//  two-cycle ERROR response for out-of-range or oversize accesses.
// PARAMETERS
//  BUS_WDT      32  data bus width (32 or 64)
//  DEPTH_LOG2   10  log2 of SRAM depth in BUS_WDT-bit words
//  WAIT_STATES  0   wait cycles inserted per OKAY data phase (0..15)
// PORTS
//  i_hclk      in   1        bus clock, all logic on rising edge
//  i_hreset_n  in   1        asynchronous active-low reset
//  i_hsel      in   1        slave select from decoder
//  i_haddr     in   32       byte address
//  i_htrans    in   2        0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//  i_hwrite    in   1        1 write, 0 read
//  i_hsize     in   2        0 byte, 1 half, 2 word, 3 dword
//  i_hburst    in   2        accepted, ignored (each beat carries its address)
//  i_hwdata    in   BUS_WDT  write data, valid in data phase
//  i_hready    in   1        bus-wide HREADY (end of previous data phase)
//  o_hready    out  1        slave ready; 0 extends current data phase
//  o_hresp     out  2        0 OKAY, 1 ERROR (2/3 never driven)
//  o_hrdata    out  BUS_WDT  read data, valid when o_hready=1 in read data phase
// BEHAVIOUR
//  Reset (async): o_hready=1, o_hresp=0, o_hrdata=0, FSM=IDLE. SRAM not cleared.
//  Mid-transfer reset abandons the beat; a pending write is dropped.
//  Address phase accepted on edge where i_hsel & i_hready & i_htrans[1].
//   Latch addr, write, size. IDLE/BUSY or !i_hsel: no access; next data phase
//   returns OKAY with zero waits.
//  Error check at acceptance: word index >= 2**DEPTH_LOG2, or
//   8<<hsize > BUS_WDT, or addr not size-aligned -> ERROR path.
//  FSM states:
//   IDLE: o_hready=1, o_hresp=OKAY. Accepted good xfer -> WAIT if
//     WAIT_STATES>0, else DATA. Accepted bad xfer -> ERR1.
//   WAIT: o_hready=0. Counter loads WAIT_STATES-1 and decrements. At 0 -> DATA.
//   DATA: o_hready=1, OKAY. Write: commit i_hwdata on this edge using byte
//     lanes from latched size/addr low bits; other lanes unchanged. Read:
//     o_hrdata holds the full word (all lanes). A new address phase accepted
//     on this edge is decoded as in IDLE, so there are no bubbles.
//   ERR1: o_hready=0, o_hresp=ERROR -> ERR2.
//   ERR2: o_hready=1, o_hresp=ERROR. No SRAM access. A new address phase on
//     this edge is decoded normally.
//  Latency: read data valid WAIT_STATES+1 cycles after its address-phase edge.
//  o_hrdata registered; held at last value outside read data phases.
//  Hazard: a read accepted while the previous write is in DATA returns the
//   merged (forwarded) write data, never stale SRAM contents.
//  BUSY in the middle of a burst: zero-wait OKAY, no access, counter untouched.
//  i_hsel dropped during WAIT: the accepted beat still completes.
//  Address bits above the SRAM range feed only the error check. No wrap.
// TESTING
//  1 Reset: hold i_hreset_n=0 -> o_hready=1, o_hresp=0, o_hrdata=0.
//  2 WAIT_STATES=0: NONSEQ write word 0xDEADBEEF @0x0, then read @0x0 next
//    cycle -> o_hrdata=0xDEADBEEF via forwarding, hready never low.
//  3 Byte write 0xAA @0x3 over word 0x11223344 @0x0, read @0x0
//    -> 0xAA223344, with lanes 0..2 unchanged.
//  4 WAIT_STATES=2: read @0x8 -> o_hready=0 for exactly 2 cycles, then 1 with
//    data. Back-to-back SEQ burst of 4 beats -> 12 data-phase cycles total.
//  5 Write @ (4<<DEPTH_LOG2) -> cycle1 hready=0/hresp=1, cycle2 hready=1/hresp=1.
//    Later read of the word it would alias shows unchanged SRAM contents.
//  6 i_htrans=BUSY between SEQ beats, and misaligned half @0x1 -> BUSY gives
//    zero-wait OKAY, misaligned half gives two-cycle ERROR.

Source files
------------

// File: rtl/ahb_slave_sram.sv
// ahb_slave_sram: AHB responder backed by a word-addressed SRAM.
// Fixed wait-state insertion, byte/half/word lanes, two-cycle ERROR response.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no data phase in flight, zero-wait OKAY
// WAIT  | accepted good beat, stalling WAIT_STATES cycles
// DATA  | final data-phase cycle: write commits / read data presented
// ERR1  | first ERROR cycle, hready low
// ERR2  | second ERROR cycle, hready high, next address phase decoded
module ahb_slave_sram #(
  parameter int BUS_WDT     = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic               i_hclk,
  input  logic               i_hreset_n,
  input  logic               i_hsel,
  input  logic [31:0]        i_haddr,
  input  logic [1:0]         i_htrans,
  input  logic               i_hwrite,
  input  logic [1:0]         i_hsize,
  input  logic [1:0]         i_hburst,
  input  logic [BUS_WDT-1:0] i_hwdata,
  input  logic               i_hready,
  output logic               o_hready,
  output logic [1:0]         o_hresp,
  output logic [BUS_WDT-1:0] o_hrdata
);

  localparam int LANES   = BUS_WDT / 8;
  localparam int LSB     = $clog2(LANES);
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int WS_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t                state, state_nxt;
  logic [BUS_WDT-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [LSB-1:0]        lat_off;
  logic [1:0]            lat_size;
  logic                  lat_write;
  logic [3:0]            wait_cnt;

  logic                  addr_phase, take, req_err, load_rd, fwd;
  logic [2:0]            align_mask;
  logic [LANES-1:0]      wr_mask;
  logic [BUS_WDT-1:0]    wr_word, rd_word;
  logic [DEPTH_LOG2-1:0] rd_idx;

  // Burst type only shapes the master's address sequence; every beat carries its own address.
  logic unused_bits;
  assign unused_bits = ^{i_hburst, i_htrans[0]};

  assign addr_phase = i_hsel & i_hready & i_htrans[1];
  assign take = addr_phase && (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);

  // Reject out-of-range, wider-than-bus and misaligned requests at acceptance.
  always_comb begin
    case (i_hsize)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    req_err = ((i_haddr >> (DEPTH_LOG2 + LSB)) != 32'd0) ||
              (int'(i_hsize) > LSB) ||
              ((i_haddr[2:0] & align_mask) != 3'd0);
  end

  // State register.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next state and response outputs; IDLE, DATA and ERR2 all decode a new address phase.
  always_comb begin
    state_nxt = state;
    o_hready  = 1'b1;
    o_hresp   = 2'b00;
    case (state)
      ST_WAIT: begin
        o_hready = 1'b0;
        if (wait_cnt == 4'd0) state_nxt = ST_DATA;
      end
      ST_ERR1: begin
        o_hready  = 1'b0;
        o_hresp   = 2'b01;
        state_nxt = ST_ERR2;
      end
      default: begin
        if (state == ST_ERR2) o_hresp = 2'b01;
        if (addr_phase) begin
          if (req_err)              state_nxt = ST_ERR1;
          else if (WAIT_STATES > 0) state_nxt = ST_WAIT;
          else                      state_nxt = ST_DATA;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Capture the address-phase controls and run the wait-state down-counter.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      lat_idx   <= '0;
      lat_off   <= '0;
      lat_size  <= 2'd0;
      lat_write <= 1'b0;
      wait_cnt  <= 4'd0;
    end else begin
      if (take) begin
        lat_idx   <= i_haddr[LSB +: DEPTH_LOG2];
        lat_off   <= i_haddr[LSB-1:0];
        lat_size  <= i_hsize;
        lat_write <= i_hwrite;
      end
      if (take && !req_err)
        wait_cnt <= WS_LOAD[3:0];
      else if (state == ST_WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Lanes covered by the latched access: those sharing the offset's size-aligned slot.
  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < LANES; i++)
      if ((i >> lat_size) == (int'(lat_off) >> lat_size)) wr_mask[i] = 1'b1;
  end

  // Merge incoming write lanes over the current word.
  always_comb begin
    wr_word = mem[lat_idx];
    for (int i = 0; i < LANES; i++)
      if (wr_mask[i]) wr_word[8*i +: 8] = i_hwdata[8*i +: 8];
  end

  // SRAM write port; contents survive reset.
  always_ff @(posedge i_hclk) begin
    if (state == ST_DATA && lat_write) mem[lat_idx] <= wr_word;
  end

  // With no wait states the read index comes straight off the bus, and a write
  // committing on the same edge to the same word must be forwarded.
  assign rd_idx  = (state == ST_WAIT) ? lat_idx : i_haddr[LSB +: DEPTH_LOG2];
  assign fwd     = (state == ST_DATA) && lat_write && (lat_idx == rd_idx);
  assign rd_word = fwd ? wr_word : mem[rd_idx];
  assign load_rd = (state_nxt == ST_DATA) && ((state == ST_WAIT) ? !lat_write : !i_hwrite);

  // Registered read data, loaded on the edge entering a read's DATA cycle.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n)  o_hrdata <= '0;
    else if (load_rd) o_hrdata <= rd_word;
  end

endmodule

// File: tb/tb_ahb_slave_sram.sv
// tb_ahb_slave_sram: two slave instances (0 and 2 wait states) driven by a
// pipelined AHB master model; directed tables plus randomized beats checked
// against a byte-array memory model.
module tb_ahb_slave_sram;

  localparam int DL2     = 6;
  localparam int WS0     = 0;
  localparam int WS1     = 2;
  localparam int RANGE_B = 4 << DL2;

  localparam bit [1:0] ID = 2'd0, BZ = 2'd1, NS = 2'd2, SQ = 2'd3;
  localparam bit [1:0] B8 = 2'd0, H16 = 2'd1, W32 = 2'd2, D64 = 2'd3;
  localparam bit [1:0] OK = 2'd0, ER = 2'd1;

  typedef struct {
    int        grp;
    bit        sel;
    bit [1:0]  trans;
    bit        wr;
    bit [1:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [1:0]  exp_resp;
    int        exp_waits;
    bit [31:0] exp_rdata;
    bit [31:0] exp_mask;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel [2];
  logic [31:0] haddr [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [1:0]  hsize [2];
  logic [1:0]  hburst [2];
  logic [31:0] hwdata [2];
  logic        hready_in [2];
  logic        hready_out [2];
  logic [1:0]  hresp [2];
  logic [31:0] hrdata [2];

  int nvec, nerr;
  vec_t tbl[$];
  vec_t seq[$];
  bit [7:0] mdat [2][RANGE_B];
  bit       mkn  [2][RANGE_B];

  always #5 clk = ~clk;

  assign hready_in[0] = hready_out[0];
  assign hready_in[1] = hready_out[1];

  ahb_slave_sram #(.BUS_WDT(32), .DEPTH_LOG2(DL2), .WAIT_STATES(WS0)) dut0 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel[0]), .i_haddr(haddr[0]),
    .i_htrans(htrans[0]), .i_hwrite(hwrite[0]), .i_hsize(hsize[0]), .i_hburst(hburst[0]),
    .i_hwdata(hwdata[0]), .i_hready(hready_in[0]), .o_hready(hready_out[0]),
    .o_hresp(hresp[0]), .o_hrdata(hrdata[0]));

  ahb_slave_sram #(.BUS_WDT(32), .DEPTH_LOG2(DL2), .WAIT_STATES(WS1)) dut1 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel[1]), .i_haddr(haddr[1]),
    .i_htrans(htrans[1]), .i_hwrite(hwrite[1]), .i_hsize(hsize[1]), .i_hburst(hburst[1]),
    .i_hwdata(hwdata[1]), .i_hready(hready_in[1]), .o_hready(hready_out[1]),
    .o_hresp(hresp[1]), .o_hrdata(hrdata[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int grp, input bit sel, input bit [1:0] trans, input bit wr,
                              input bit [1:0] size, input bit [31:0] addr, input bit [31:0] wdata,
                              input bit [1:0] eresp, input int ewaits, input bit [31:0] erd,
                              input bit [31:0] emask);
    vec_t v;
    v.grp = grp; v.sel = sel; v.trans = trans; v.wr = wr; v.size = size;
    v.addr = addr; v.wdata = wdata; v.exp_resp = eresp; v.exp_waits = ewaits;
    v.exp_rdata = erd; v.exp_mask = emask;
    return v;
  endfunction

  // Reference: a byte-addressed memory with a known-byte map; bus rules applied directly.
  function automatic vec_t model_step(input int d, input vec_t v);
    vec_t m = v;
    int nb;
    int base;
    m.exp_resp = OK; m.exp_waits = 0; m.exp_rdata = 0; m.exp_mask = 0;
    if (!(v.sel && v.trans[1])) return m;
    nb = 1 << v.size;
    if (v.addr >= 32'(RANGE_B) || nb > 4 || (int'(v.addr[2:0]) % nb) != 0) begin
      m.exp_resp = ER; m.exp_waits = 1;
      return m;
    end
    m.exp_waits = (d == 0) ? WS0 : WS1;
    if (v.wr) begin
      for (int k = 0; k < nb; k++) begin
        int b = int'(v.addr) + k;
        mdat[d][b] = v.wdata[8*(b%4) +: 8];
        mkn[d][b]  = 1'b1;
      end
    end else begin
      base = (int'(v.addr) / 4) * 4;
      for (int k = 0; k < 4; k++) begin
        m.exp_rdata[8*k +: 8] = mdat[d][base+k];
        if (mkn[d][base+k]) m.exp_mask[8*k +: 8] = 8'hFF;
      end
    end
    return m;
  endfunction

  task automatic drive_idle(input int d);
    hsel[d] = 1'b0; htrans[d] = ID; hwrite[d] = 1'b0; hsize[d] = W32;
    haddr[d] = 32'h0; hburst[d] = 2'd0; hwdata[d] = 32'h0;
  endtask

  // Pipelined master: address phase of beat ai overlaps data phase of beat di.
  task automatic run_seq(input int d, output int dcyc);
    int ai, di, waits, cyc;
    logic rdy;
    logic [1:0] rsp;
    logic [31:0] rd;
    ai = 0; di = -1; waits = 0; cyc = 0; dcyc = 0;
    while ((ai < seq.size() || di >= 0) && cyc < 5000) begin
      if (ai < seq.size()) begin
        hsel[d] = seq[ai].sel; htrans[d] = seq[ai].trans; hwrite[d] = seq[ai].wr;
        hsize[d] = seq[ai].size; haddr[d] = seq[ai].addr; hburst[d] = 2'd1;
      end else begin
        hsel[d] = 1'b0; htrans[d] = ID;
      end
      hwdata[d] = (di >= 0) ? seq[di].wdata : 32'h0;
      @(negedge clk);
      rdy = hready_out[d]; rsp = hresp[d]; rd = hrdata[d];
      if (di >= 0) begin
        dcyc++;
        if (!rdy) begin
          waits++;
          chk($sformatf("d%0d beat%0d low-cycle hresp", d, di), 32'(rsp), 32'(seq[di].exp_resp));
        end else begin
          chk($sformatf("d%0d beat%0d waits", d, di), 32'(waits), 32'(seq[di].exp_waits));
          chk($sformatf("d%0d beat%0d hresp", d, di), 32'(rsp), 32'(seq[di].exp_resp));
          if (seq[di].exp_mask != 32'h0)
            chk($sformatf("d%0d beat%0d rdata@%h", d, di, seq[di].addr),
                rd & seq[di].exp_mask, seq[di].exp_rdata & seq[di].exp_mask);
        end
      end else begin
        chk($sformatf("d%0d idle hready", d), 32'(rdy), 32'd1);
      end
      @(posedge clk); #1;
      if (rdy) begin
        di = (ai < seq.size()) ? ai : -1;
        if (ai < seq.size()) ai++;
        waits = 0;
      end
      cyc++;
    end
    if (cyc >= 5000) chk($sformatf("d%0d timeout", d), 32'd1, 32'd0);
    drive_idle(d);
    seq.delete();
  endtask

  task automatic run_group(input int g, output int dcyc);
    int d = (g == 0) ? 0 : 1;
    foreach (tbl[i]) begin
      if (tbl[i].grp == g) begin
        void'(model_step(d, tbl[i]));
        seq.push_back(tbl[i]);
      end
    end
    run_seq(d, dcyc);
  endtask

  initial begin
    vec_t v;
    int c, r, word, off;
    nvec = 0; nerr = 0;
    rst_n = 1'b0;
    drive_idle(0); drive_idle(1);

    // grp 0: zero-wait instance
    tbl.push_back(mk(0, 1, NS, 1, W32, 32'h0,   32'hDEADBEEF, OK, 0, 0, 0));
    tbl.push_back(mk(0, 1, NS, 0, W32, 32'h0,   32'h0,        OK, 0, 32'hDEADBEEF, 32'hFFFFFFFF));
    tbl.push_back(mk(0, 1, NS, 1, W32, 32'h0,   32'h11223344, OK, 0, 0, 0));
    tbl.push_back(mk(0, 1, NS, 1, B8,  32'h3,   32'hAA000000, OK, 0, 0, 0));
    tbl.push_back(mk(0, 1, NS, 0, W32, 32'h0,   32'h0,        OK, 0, 32'hAA223344, 32'hFFFFFFFF));
    tbl.push_back(mk(0, 1, NS, 1, W32, 32'h100, 32'hFFFFFFFF, ER, 1, 0, 0));
    tbl.push_back(mk(0, 1, NS, 0, W32, 32'h0,   32'h0,        OK, 0, 32'hAA223344, 32'hFFFFFFFF));
    tbl.push_back(mk(0, 1, NS, 1, W32, 32'h4,   32'h01020304, OK, 0, 0, 0));
    tbl.push_back(mk(0, 1, SQ, 1, W32, 32'h8,   32'h05060708, OK, 0, 0, 0));
    tbl.push_back(mk(0, 1, BZ, 1, W32, 32'hC,   32'hFFFFFFFF, OK, 0, 0, 0));
    tbl.push_back(mk(0, 1, SQ, 1, W32, 32'hC,   32'h090A0B0C, OK, 0, 0, 0));
    tbl.push_back(mk(0, 1, NS, 0, H16, 32'h1,   32'h0,        ER, 1, 0, 0));
    tbl.push_back(mk(0, 1, NS, 0, W32, 32'h8,   32'h0,        OK, 0, 32'h05060708, 32'hFFFFFFFF));
    tbl.push_back(mk(0, 1, ID, 0, W32, 32'h0,   32'h0,        OK, 0, 0, 0));
    tbl.push_back(mk(0, 1, NS, 0, H16, 32'h6,   32'h0,        OK, 0, 32'h01020304, 32'hFFFFFFFF));
    tbl.push_back(mk(0, 0, NS, 0, W32, 32'h0,   32'h0,        OK, 0, 0, 0));
    tbl.push_back(mk(0, 1, NS, 0, B8,  32'hC,   32'h0,        OK, 0, 32'h090A0B0C, 32'hFFFFFFFF));
    tbl.push_back(mk(0, 1, NS, 1, H16, 32'h2,   32'hBEEF0000, OK, 0, 0, 0));
    tbl.push_back(mk(0, 1, NS, 0, W32, 32'h0,   32'h0,        OK, 0, 32'hBEEF3344, 32'hFFFFFFFF));
    tbl.push_back(mk(0, 1, NS, 0, D64, 32'h0,   32'h0,        ER, 1, 0, 0));
    // grp 1: two-wait instance, setup writes
    tbl.push_back(mk(1, 1, NS, 1, W32, 32'h8,   32'hCAFEF00D, OK, 2, 0, 0));
    tbl.push_back(mk(1, 1, NS, 0, W32, 32'h8,   32'h0,        OK, 2, 32'hCAFEF00D, 32'hFFFFFFFF));
    tbl.push_back(mk(1, 1, NS, 1, W32, 32'h8,   32'h11111111, OK, 2, 0, 0));
    tbl.push_back(mk(1, 1, SQ, 1, W32, 32'hC,   32'h22222222, OK, 2, 0, 0));
    tbl.push_back(mk(1, 1, SQ, 1, W32, 32'h10,  32'h33333333, OK, 2, 0, 0));
    tbl.push_back(mk(1, 1, SQ, 1, W32, 32'h14,  32'h44444444, OK, 2, 0, 0));
    tbl.push_back(mk(1, 1, NS, 0, W32, 32'h14,  32'h0,        OK, 2, 32'h44444444, 32'hFFFFFFFF));
    // grp 2: four-beat read burst
    tbl.push_back(mk(2, 1, NS, 0, W32, 32'h8,   32'h0,        OK, 2, 32'h11111111, 32'hFFFFFFFF));
    tbl.push_back(mk(2, 1, SQ, 0, W32, 32'hC,   32'h0,        OK, 2, 32'h22222222, 32'hFFFFFFFF));
    tbl.push_back(mk(2, 1, SQ, 0, W32, 32'h10,  32'h0,        OK, 2, 32'h33333333, 32'hFFFFFFFF));
    tbl.push_back(mk(2, 1, SQ, 0, W32, 32'h14,  32'h0,        OK, 2, 32'h44444444, 32'hFFFFFFFF));
    // grp 3: after mid-transfer reset; hsel drop during WAIT; BUSY; misaligned half
    tbl.push_back(mk(3, 1, NS, 0, W32, 32'h14,  32'h0,        OK, 2, 32'h44444444, 32'hFFFFFFFF));
    tbl.push_back(mk(3, 1, NS, 0, W32, 32'h10,  32'h0,        OK, 2, 32'h33333333, 32'hFFFFFFFF));
    tbl.push_back(mk(3, 0, NS, 1, W32, 32'h10,  32'hFFFFFFFF, OK, 0, 0, 0));
    tbl.push_back(mk(3, 1, NS, 0, W32, 32'h8,   32'h0,        OK, 2, 32'h11111111, 32'hFFFFFFFF));
    tbl.push_back(mk(3, 1, BZ, 0, W32, 32'hC,   32'h0,        OK, 0, 0, 0));
    tbl.push_back(mk(3, 1, SQ, 0, W32, 32'hC,   32'h0,        OK, 2, 32'h22222222, 32'hFFFFFFFF));
    tbl.push_back(mk(3, 1, NS, 1, H16, 32'h3,   32'hFFFFFFFF, ER, 1, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset hready", d), 32'(hready_out[d]), 32'd1);
      chk($sformatf("d%0d reset hresp", d), 32'(hresp[d]), 32'd0);
      chk($sformatf("d%0d reset hrdata", d), hrdata[d], 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_group(0, c);
    run_group(1, c);
    run_group(2, c);
    chk("burst data-phase cycles", 32'(c), 32'd12);

    // Write abandoned by a reset asserted during its wait states.
    hsel[1] = 1'b1; htrans[1] = NS; hwrite[1] = 1'b1; hsize[1] = W32; haddr[1] = 32'h14;
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = ID; hwdata[1] = 32'hFFFFFFFF;
    @(negedge clk);
    chk("mid-reset wait hready", 32'(hready_out[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid-reset hready", 32'(hready_out[1]), 32'd1);
    chk("mid-reset hresp", 32'(hresp[1]), 32'd0);
    chk("mid-reset hrdata", hrdata[1], 32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drive_idle(1);
    run_group(3, c);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        v.grp = 9;
        v.sel = ($urandom_range(0, 9) != 0);
        r = int'($urandom_range(0, 9));
        v.trans = (r == 0) ? ID : (r == 1) ? BZ : (r < 6) ? NS : SQ;
        v.wr = ($urandom_range(0, 1) != 0);
        v.size = ($urandom_range(0, 9) == 0) ? D64 : 2'($urandom_range(0, 2));
        word = int'($urandom_range(0, (1 << DL2) - 1));
        if ($urandom_range(0, 7) == 0) off = int'($urandom_range(0, 3));
        else if (v.size == D64) off = 0;
        else off = (int'($urandom_range(0, 3)) >> v.size) << v.size;
        v.addr = 32'(word * 4 + off);
        if ($urandom_range(0, 15) == 0) v.addr = v.addr | (32'h1 << $urandom_range(DL2 + 2, 31));
        v.wdata = $urandom();
        seq.push_back(model_step(d, v));
      end
      run_seq(d, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
